// File: rtl/neuron_pkg.sv
// Shared definitions for the spike arbitration blocks.
//
// 4-phase channel convention used on every req/ack pair:
//   1. sender raises req (and holds any data stable)
//   2. receiver raises ack once it has taken the data
//   3. sender drops req
//   4. receiver drops ack; the channel is idle again
// Neuron requests and downstream acknowledges are asynchronous to clk and
// must be synchronised before any state machine looks at them.
package neuron_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        RTZ  = 2'd2,
        REL  = 2'd3
    } arb_state_t;

    localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/spike_sync.sv
// Single-bit flip-flop synchroniser with asynchronous active-low clear.
//
// Ports:
//   clk   in  1  destination clock
//   rst_n in  1  asynchronous active-low clear of every stage
//   d     in  1  asynchronous input
//   q     out 1  synchronised copy, STAGES cycles behind d
module spike_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/spike_rr_arbiter.sv
// Round-robin arbiter merging N_IN 4-phase neuron request channels into one
// address-event output channel. The index of the granted neuron is sent on
// addr_out; simultaneous spikes are serialised in rotating priority order.
//
// Ports:
//   clk       in  1       system clock, rising edge
//   rst_n     in  1       asynchronous active-low reset
//   req_in    in  N_IN    asynchronous 4-phase requests from the neurons
//   ack_in    out N_IN    acknowledges back to the neurons, one-hot or zero
//   addr_out  out ADDR_W  granted neuron index, valid while req_out=1
//   req_out   out 1       4-phase request to the downstream consumer
//   ack_out   in  1       asynchronous acknowledge from downstream
//   busy      out 1       high whenever the FSM is not IDLE
//   evt_count out CNT_W   completed transfers, wraps modulo 2^CNT_W
module spike_rr_arbiter
    import neuron_pkg::*;
#(
    parameter int N_IN        = 4,
    parameter int ADDR_W      = $clog2(N_IN),
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_IN-1:0]   req_in,
    output logic [N_IN-1:0]   ack_in,
    output logic [ADDR_W-1:0] addr_out,
    output logic              req_out,
    input  logic              ack_out,
    output logic              busy,
    output logic [CNT_W-1:0]  evt_count
);

    logic [N_IN-1:0]   req_s;
    logic              ack_s;

    arb_state_t        state_q,   state_d;
    logic [ADDR_W-1:0] ptr_q,     ptr_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic              req_out_q, req_out_d;
    logic [N_IN-1:0]   ack_in_q,  ack_in_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;

    for (genvar i = 0; i < N_IN; i++) begin : g_req_sync
        spike_sync #(.STAGES(SYNC_STAGES)) u_req_sync (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (req_in[i]),
            .q     (req_s[i])
        );
    end

    spike_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ack_out),
        .q     (ack_s)
    );

    // Rotate the request vector so the pointer position lands on bit 0,
    // take the lowest set bit, then add the pointer back modulo N_IN.
    function automatic logic [ADDR_W-1:0] rr_pick(input logic [N_IN-1:0]   req,
                                                 input logic [ADDR_W-1:0] ptr);
        logic [2*N_IN-1:0] dbl;
        logic [N_IN-1:0]   rot;
        int                enc;
        int                sum;
        dbl = {req, req};
        rot = N_IN'(dbl >> ptr);
        enc = 0;
        for (int k = N_IN - 1; k >= 0; k--) begin
            if (rot[k]) begin
                enc = k;
            end
        end
        sum = enc + int'(ptr);
        if (sum >= N_IN) begin
            sum = sum - N_IN;
        end
        return ADDR_W'(sum);
    endfunction

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        addr_d    = addr_q;
        req_out_d = req_out_q;
        ack_in_d  = ack_in_q;
        cnt_d     = cnt_q;

        case (state_q)
            IDLE: begin
                if (|req_s) begin
                    addr_d    = rr_pick(req_s, ptr_q);
                    req_out_d = 1'b1;
                    state_d   = SEND;
                end
            end
            SEND: begin
                // Dropping req_out and raising the neuron ack on the same
                // edge keeps the two from ever being high together.
                if (ack_s) begin
                    req_out_d        = 1'b0;
                    ack_in_d         = '0;
                    ack_in_d[addr_q] = 1'b1;
                    state_d          = RTZ;
                end
            end
            RTZ: begin
                // A neuron that dropped its request early (protocol
                // violation) already has req_s low, so only ack_s gates exit.
                if (!ack_s && !req_s[addr_q]) begin
                    ack_in_d = '0;
                    cnt_d    = cnt_q + 1'b1;
                    ptr_d    = (addr_q == ADDR_W'(N_IN - 1)) ? '0 : addr_q + 1'b1;
                    state_d  = REL;
                end
            end
            REL: begin
                // Gap cycle so the neuron sees ack_in low before any new grant.
                req_out_d = 1'b0;
                ack_in_d  = '0;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            addr_q    <= '0;
            req_out_q <= 1'b0;
            ack_in_q  <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            addr_q    <= addr_d;
            req_out_q <= req_out_d;
            ack_in_q  <= ack_in_d;
            cnt_q     <= cnt_d;
        end
    end

    assign ack_in    = ack_in_q;
    assign addr_out  = addr_q;
    assign req_out   = req_out_q;
    assign busy      = (state_q != IDLE);
    assign evt_count = cnt_q;

endmodule
